// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter slice.
//   ALUOP_W / TAG_W : default widths of the one-hot op vector and requester tag
//   OP_ADD..OP_LUI  : bit positions inside the one-hot aluop vector
//   req_t / rsp_t   : request and response bundles as seen by a requester
package alu_pkg;

  localparam int ALUOP_W = 12;
  localparam int TAG_W   = 4;

  localparam int OP_ADD  = 11;
  localparam int OP_SUB  = 10;
  localparam int OP_AND  = 9;
  localparam int OP_OR   = 8;
  localparam int OP_NOR  = 7;
  localparam int OP_XOR  = 6;
  localparam int OP_SLT  = 5;
  localparam int OP_SLTU = 4;
  localparam int OP_SLL  = 3;
  localparam int OP_SRL  = 2;
  localparam int OP_SRA  = 1;
  localparam int OP_LUI  = 0;

  typedef struct packed {
    logic [31:0]        src0;
    logic [31:0]        src1;
    logic [ALUOP_W-1:0] aluop;
    logic [TAG_W-1:0]   tag;
  } req_t;

  typedef struct packed {
    logic [31:0]      result;
    logic             overflow;
    logic [TAG_W-1:0] tag;
  } rsp_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// Request/response bundle between two requesting pipes and alu_share_arb.
//   reqN_* : valid/ready request channel (operands, one-hot op, tag) for pipe N
//   rspN_* : valid/ready response channel (result, overflow, tag) for pipe N
// master = requester/consumer side, slave = arbiter side.
interface alu_share_arb_if #(
  parameter int TAG_W   = alu_pkg::TAG_W,
  parameter int ALUOP_W = alu_pkg::ALUOP_W
) ();

  logic               req0_valid;
  logic               req0_ready;
  logic [31:0]        req0_src0;
  logic [31:0]        req0_src1;
  logic [ALUOP_W-1:0] req0_aluop;
  logic [TAG_W-1:0]   req0_tag;

  logic               req1_valid;
  logic               req1_ready;
  logic [31:0]        req1_src0;
  logic [31:0]        req1_src1;
  logic [ALUOP_W-1:0] req1_aluop;
  logic [TAG_W-1:0]   req1_tag;

  logic               rsp0_valid;
  logic               rsp0_ready;
  logic [31:0]        rsp0_result;
  logic               rsp0_overflow;
  logic [TAG_W-1:0]   rsp0_tag;

  logic               rsp1_valid;
  logic               rsp1_ready;
  logic [31:0]        rsp1_result;
  logic               rsp1_overflow;
  logic [TAG_W-1:0]   rsp1_tag;

  modport master (
    output req0_valid, req0_src0, req0_src1, req0_aluop, req0_tag,
    input  req0_ready,
    output req1_valid, req1_src0, req1_src1, req1_aluop, req1_tag,
    input  req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_overflow, rsp0_tag,
    output rsp0_ready,
    input  rsp1_valid, rsp1_result, rsp1_overflow, rsp1_tag,
    output rsp1_ready
  );

  modport slave (
    input  req0_valid, req0_src0, req0_src1, req0_aluop, req0_tag,
    output req0_ready,
    input  req1_valid, req1_src0, req1_src1, req1_aluop, req1_tag,
    output req1_ready,
    output rsp0_valid, rsp0_result, rsp0_overflow, rsp0_tag,
    input  rsp0_ready,
    output rsp1_valid, rsp1_result, rsp1_overflow, rsp1_tag,
    input  rsp1_ready
  );

endinterface

// File: rtl/alu_share_arb_alu.sv
// 32-bit combinational ALU with one-hot operation select.
//   aluop    : one-hot op (OP_* bit positions); all-zero yields result 0
//   src0     : operand 0, shift amount in [4:0] for shifts
//   src1     : operand 1, value shifted for shifts, immediate for lui
//   result   : OR of the selected operation's result
//   overflow : signed overflow of the shared adder (meaningful for add/sub)
module alu
  import alu_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [31:0]        src0,
  input  logic [31:0]        src1,
  output logic [31:0]        result,
  output logic               overflow
);

  logic        sub_mode;
  logic [31:0] b_in;
  logic [31:0] sum;
  logic        cout;
  logic        slt;
  logic        sltu;

  always_comb begin
    // One adder serves add, sub and both compares; compares run it as a subtract.
    sub_mode      = aluop[OP_SUB] | aluop[OP_SLT] | aluop[OP_SLTU];
    b_in          = sub_mode ? ~src1 : src1;
    {cout, sum}   = {1'b0, src0} + {1'b0, b_in} + {32'b0, sub_mode};
    overflow      = (src0[31] == b_in[31]) & (sum[31] != src0[31]);
    slt           = (src0[31] & ~src1[31]) | (~(src0[31] ^ src1[31]) & sum[31]);
    sltu          = ~cout;

    result = '0;
    if (aluop[OP_ADD] | aluop[OP_SUB]) result = result | sum;
    if (aluop[OP_AND])  result = result | (src0 & src1);
    if (aluop[OP_OR])   result = result | (src0 | src1);
    if (aluop[OP_NOR])  result = result | ~(src0 | src1);
    if (aluop[OP_XOR])  result = result | (src0 ^ src1);
    if (aluop[OP_SLT])  result = result | {31'b0, slt};
    if (aluop[OP_SLTU]) result = result | {31'b0, sltu};
    if (aluop[OP_SLL])  result = result | (src1 << src0[4:0]);
    if (aluop[OP_SRL])  result = result | (src1 >> src0[4:0]);
    if (aluop[OP_SRA])  result = result | 32'($signed(src1) >>> src0[4:0]);
    if (aluop[OP_LUI])  result = result | {src1[15:0], 16'h0000};
  end

endmodule

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin arbiter with enable.
//   clk, resetn : clock, asynchronous active-low reset (pointer -> pipe 0)
//   en          : grants are allowed this cycle
//   req         : request vector, bit N = pipe N
//   gnt         : one-hot grant vector (zero when nothing is granted)
//   gnt_id      : index of the granted pipe (0 when nothing is granted)
module rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt    = '0;
    gnt_id = 1'b0;
    if (en && (req != 2'b00)) begin
      gnt_id = (req == 2'b11) ? ptr_q : req[1];
      gnt    = gnt_id ? 2'b10 : 2'b01;
    end
    // The loser of a grant gets priority next; pointer holds when idle.
    ptr_d = (gnt != 2'b00) ? ~gnt_id : ptr_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between two requesting pipes with round-robin arbitration
// and a single registered result stage (latency 1, 1 op/cycle throughput).
//   clk    : clock, all state on rising edge
//   resetn : asynchronous active-low reset
//   flush  : kills the in-flight result and blocks grants this cycle
//   bus    : request/response channels for pipe 0 and pipe 1
module alu_share_arb #(
  parameter int TAG_W   = alu_pkg::TAG_W,
  parameter int ALUOP_W = alu_pkg::ALUOP_W
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           flush,
  alu_share_arb_if.slave bus
);

  import alu_pkg::OP_ADD;
  import alu_pkg::OP_SUB;

  logic               out_valid_q, out_valid_d;
  logic               out_id_q,    out_id_d;
  logic [31:0]        result_q,    result_d;
  logic               ovf_q,       ovf_d;
  logic [TAG_W-1:0]   tag_q,       tag_d;

  logic [1:0]         req_valid;
  logic [1:0]         gnt;
  logic               gnt_id;
  logic               drain;
  logic               arb_en;
  logic [31:0]        alu_a;
  logic [31:0]        alu_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [TAG_W-1:0]   sel_tag;
  logic [31:0]        alu_result;
  logic               alu_ovf;

  always_comb begin
    req_valid = {bus.req1_valid, bus.req0_valid};
    drain     = out_valid_q & (out_id_q ? bus.rsp1_ready : bus.rsp0_ready);
    // resetn term keeps both readies low while reset is held.
    arb_en    = (~out_valid_q | drain) & ~flush & resetn;
  end

  rr_arb2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .en     (arb_en),
    .req    (req_valid),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_comb begin
    alu_a   = gnt_id ? bus.req1_src0  : bus.req0_src0;
    alu_b   = gnt_id ? bus.req1_src1  : bus.req0_src1;
    alu_op  = gnt_id ? bus.req1_aluop : bus.req0_aluop;
    sel_tag = gnt_id ? bus.req1_tag   : bus.req0_tag;
  end

  alu u_alu (
    .aluop    (alu_op),
    .src0     (alu_a),
    .src1     (alu_b),
    .result   (alu_result),
    .overflow (alu_ovf)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    tag_d       = tag_q;
    // flush wins over a same-cycle drain; a grant cannot coexist with flush.
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (gnt != 2'b00) begin
      out_valid_d = 1'b1;
      out_id_d    = gnt_id;
      result_d    = alu_result;
      ovf_d       = alu_ovf & (alu_op[OP_ADD] | alu_op[OP_SUB]);
      tag_d       = sel_tag;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      tag_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      tag_q       <= tag_d;
    end
  end

  always_comb begin
    bus.req0_ready    = gnt[0];
    bus.req1_ready    = gnt[1];
    bus.rsp0_valid    = out_valid_q & ~out_id_q;
    bus.rsp1_valid    = out_valid_q &  out_id_q;
    bus.rsp0_result   = result_q;
    bus.rsp1_result   = result_q;
    bus.rsp0_overflow = ovf_q;
    bus.rsp1_overflow = ovf_q;
    bus.rsp0_tag      = tag_q;
    bus.rsp1_tag      = tag_q;
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: directed scenarios followed by random
// traffic, all checked against a behavioural reference model.
module tb_alu_share_arb;
  import alu_pkg::*;

  typedef struct {
    int   pipe;
    rsp_t rsp;
  } exp_t;

  localparam longint SMAX = 64'sh7FFFFFFF;
  localparam longint SMIN = -64'sh80000000;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  logic flush  = 1'b0;

  always #5 clk = ~clk;

  alu_share_arb_if #(.TAG_W(TAG_W), .ALUOP_W(ALUOP_W)) bus ();

  alu_share_arb #(.TAG_W(TAG_W), .ALUOP_W(ALUOP_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .bus    (bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   gcount = 0;
  req_t q0[$];
  req_t q1[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU: plain arithmetic on the decoded operation.
  function automatic rsp_t ref_alu(input logic [ALUOP_W-1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [TAG_W-1:0] tag);
    rsp_t   x;
    longint sa, sbv, s;
    int     k;
    sa  = $signed(a);
    sbv = $signed(b);
    x.result = '0;
    x.overflow = 1'b0;
    x.tag = tag;
    k = -1;
    for (int i = 0; i < ALUOP_W; i++) if (op[i]) k = i;
    case (k)
      OP_ADD:  begin s = sa + sbv; x.result = s[31:0]; x.overflow = (s > SMAX) || (s < SMIN); end
      OP_SUB:  begin s = sa - sbv; x.result = s[31:0]; x.overflow = (s > SMAX) || (s < SMIN); end
      OP_AND:  x.result = a & b;
      OP_OR:   x.result = a | b;
      OP_NOR:  x.result = ~(a | b);
      OP_XOR:  x.result = a ^ b;
      OP_SLT:  x.result = (sa < sbv) ? 32'd1 : 32'd0;
      OP_SLTU: x.result = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  x.result = b << a[4:0];
      OP_SRL:  x.result = b >> a[4:0];
      OP_SRA:  begin s = sbv >>> a[4:0]; x.result = s[31:0]; end
      OP_LUI:  x.result = {b[15:0], 16'h0000};
      default: x.result = '0;
    endcase
    return x;
  endfunction

  task automatic push(input int p, input int opi, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    req_t r;
    r.src0  = a;
    r.src1  = b;
    r.aluop = (opi < 0) ? '0 : (ALUOP_W'(1) << opi);
    r.tag   = tag;
    if (p == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Pipe 0 requester: holds a request until it is seen accepted.
  initial begin : drv0
    logic acc;
    req_t r;
    bus.req0_valid = 1'b0;
    bus.req0_src0  = '0;
    bus.req0_src1  = '0;
    bus.req0_aluop = '0;
    bus.req0_tag   = '0;
    forever begin
      @(negedge clk);
      acc = bus.req0_valid & bus.req0_ready;
      @(posedge clk);
      #1;
      if (acc) bus.req0_valid = 1'b0;
      if (!bus.req0_valid && q0.size() > 0) begin
        r = q0.pop_front();
        bus.req0_src0  = r.src0;
        bus.req0_src1  = r.src1;
        bus.req0_aluop = r.aluop;
        bus.req0_tag   = r.tag;
        bus.req0_valid = 1'b1;
      end
    end
  end

  // Pipe 1 requester.
  initial begin : drv1
    logic acc;
    req_t r;
    bus.req1_valid = 1'b0;
    bus.req1_src0  = '0;
    bus.req1_src1  = '0;
    bus.req1_aluop = '0;
    bus.req1_tag   = '0;
    forever begin
      @(negedge clk);
      acc = bus.req1_valid & bus.req1_ready;
      @(posedge clk);
      #1;
      if (acc) bus.req1_valid = 1'b0;
      if (!bus.req1_valid && q1.size() > 0) begin
        r = q1.pop_front();
        bus.req1_src0  = r.src0;
        bus.req1_src1  = r.src1;
        bus.req1_aluop = r.aluop;
        bus.req1_tag   = r.tag;
        bus.req1_valid = 1'b1;
      end
    end
  end

  // Monitor: predicts grants from the arbitration rules, pushes expected
  // responses on acceptance, and pops/compares whenever a response is shown.
  initial begin : mon
    logic [1:0] v, r, rv, rr;
    logic       free_e;
    int         pref;
    int         g;
    exp_t       e;
    pref = 0;
    forever begin
      @(negedge clk);
      v  = {bus.req1_valid, bus.req0_valid};
      r  = {bus.req1_ready, bus.req0_ready};
      rv = {bus.rsp1_valid, bus.rsp0_valid};
      rr = {bus.rsp1_ready, bus.rsp0_ready};
      if (v[0] && !$onehot0(bus.req0_aluop)) $error("multi-hot aluop on pipe 0");
      if (v[1] && !$onehot0(bus.req1_aluop)) $error("multi-hot aluop on pipe 1");
      if (!resetn) begin
        chk("rst_req_ready", {30'b0, r}, 32'd0);
        chk("rst_rsp_valid", {30'b0, rv}, 32'd0);
        chk("rst_result", bus.rsp0_result | bus.rsp1_result, 32'd0);
        chk("rst_ovf_tag", {27'b0, bus.rsp0_overflow, bus.rsp0_tag}, 32'd0);
        sb.delete();
        pref = 0;
      end else begin
        free_e = 1'b1;
        if (sb.size() > 0) begin
          e = sb[0];
          chk("rsp_valid", {30'b0, rv}, (e.pipe == 1) ? 32'd2 : 32'd1);
          chk("rsp_result", (e.pipe == 1) ? bus.rsp1_result : bus.rsp0_result, e.rsp.result);
          chk("rsp_overflow", {31'b0, (e.pipe == 1) ? bus.rsp1_overflow : bus.rsp0_overflow},
              {31'b0, e.rsp.overflow});
          chk("rsp_tag", 32'((e.pipe == 1) ? bus.rsp1_tag : bus.rsp0_tag), 32'(e.rsp.tag));
          free_e = rr[e.pipe];
        end else begin
          chk("rsp_idle", {30'b0, rv}, 32'd0);
        end
        g = -1;
        if (free_e && !flush) begin
          if (v == 2'b11)  g = pref;
          else if (v[0])   g = 0;
          else if (v[1])   g = 1;
        end
        chk("grant", {30'b0, r}, (g < 0) ? 32'd0 : (32'd1 << g));
        if (sb.size() > 0 && (flush || rr[sb[0].pipe])) void'(sb.pop_front());
        if (g >= 0) begin
          e.pipe = g;
          if (g == 0) e.rsp = ref_alu(bus.req0_aluop, bus.req0_src0, bus.req0_src1, bus.req0_tag);
          else        e.rsp = ref_alu(bus.req1_aluop, bus.req1_src0, bus.req1_src1, bus.req1_tag);
          sb.push_back(e);
          pref = 1 - g;
          gcount++;
        end
      end
    end
  end

  initial begin : stim
    int g0;
    logic [31:0] held;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;

    // Idle after reset, then a single add on pipe 0.
    @(negedge clk);
    chk("t1_idle_valid", {30'b0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    chk("t1_idle_ready", {30'b0, bus.req1_ready, bus.req0_ready}, 32'd0);
    step();
    push(0, OP_ADD, 32'd5, 32'd7, 4'd3);
    step();
    @(negedge clk);
    chk("t1_req0_ready", {31'b0, bus.req0_ready}, 32'd1);
    @(negedge clk);
    chk("t1_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd1);
    chk("t1_result", bus.rsp0_result, 32'd12);
    chk("t1_ovf", {31'b0, bus.rsp0_overflow}, 32'd0);
    chk("t1_tag", 32'(bus.rsp0_tag), 32'd3);
    step();

    // Both pipes valid every cycle: one grant per cycle, alternating.
    for (int i = 0; i < 4; i++) begin
      push(0, OP_SUB, 32'd10, 32'd3, 4'(i));
      push(1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 4'(8 + i));
    end
    g0 = gcount;
    repeat (9) step();
    chk("t2_throughput", 32'(gcount - g0), 32'd8);

    // Signed overflow on add; same operands through sltu.
    push(0, OP_ADD, 32'h7FFF_FFFF, 32'd1, 4'd1);
    step();
    step();
    @(negedge clk);
    chk("t3_add_result", bus.rsp0_result, 32'h8000_0000);
    chk("t3_add_ovf", {31'b0, bus.rsp0_overflow}, 32'd1);
    step();
    push(0, OP_SLTU, 32'h7FFF_FFFF, 32'd1, 4'd2);
    step();
    step();
    @(negedge clk);
    chk("t3_sltu_result", bus.rsp0_result, 32'd0);
    chk("t3_sltu_ovf", {31'b0, bus.rsp0_overflow}, 32'd0);
    step();

    // Backpressure on rsp1 blocks pipe 0 until the result drains.
    bus.rsp1_ready = 1'b0;
    push(1, OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 4'd5);
    step();
    step();
    push(0, OP_ADD, 32'd1, 32'd2, 4'd6);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("t4_req0_blocked", {31'b0, bus.req0_ready}, 32'd0);
      chk("t4_rsp1_valid", {31'b0, bus.rsp1_valid}, 32'd1);
      chk("t4_rsp1_stable", bus.rsp1_result, 32'h0000_F000);
    end
    step();
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    chk("t4_req0_same_cycle", {31'b0, bus.req0_ready}, 32'd1);
    step();
    step();

    // flush while rsp0 is pending and pipe 1 waits.
    bus.rsp0_ready = 1'b0;
    push(0, OP_XOR, 32'h1234_5678, 32'hFFFF_0000, 4'd7);
    step();
    push(1, OP_OR, 32'h0000_000F, 32'h0000_00F0, 4'd9);
    step();
    flush = 1'b1;
    @(negedge clk);
    chk("t5_flush_no_grant", {31'b0, bus.req1_ready}, 32'd0);
    chk("t5_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd1);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("t5_rsp0_killed", {31'b0, bus.rsp0_valid}, 32'd0);
    chk("t5_req1_granted", {31'b0, bus.req1_ready}, 32'd1);
    step();

    // Reset during a stall drops the response asynchronously.
    step();
    push(0, OP_NOR, 32'd0, 32'd0, 4'd4);
    step();
    step();
    @(negedge clk);
    chk("t6_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_async_drop", {31'b0, bus.rsp0_valid}, 32'd0);
    chk("t6_async_result", bus.rsp0_result, 32'd0);
    push(0, OP_SRA, 32'd4, 32'h8000_0000, 4'd10);
    push(1, OP_SLL, 32'd4, 32'h0000_0001, 4'd11);
    bus.rsp0_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    chk("t6_ptr_reset", {30'b0, bus.req1_ready, bus.req0_ready}, 32'd1);
    step();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      step();
      bus.rsp0_ready = ($urandom_range(0, 3) != 0);
      bus.rsp1_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      if (q0.size() < 2 && $urandom_range(0, 2) != 0) begin
        held = rand_operand();
        push(0, int'($urandom_range(0, 12)) - ((c % 13 == 0) ? 100 : 0), held, rand_operand(),
             4'($urandom()));
      end
      if (q1.size() < 2 && $urandom_range(0, 2) != 0) begin
        held = rand_operand();
        push(1, int'($urandom_range(0, 11)), held, rand_operand(), 4'($urandom()));
      end
    end

    // Drain with bounded wait.
    step();
    flush = 1'b0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0 &&
          !bus.req0_valid && !bus.req1_valid) break;
      step();
    end
    step();
    chk("drain_empty", 32'(q0.size() + q1.size() + sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
